// File: rtl/ifetch_pkg.sv
// Shared widths and FSM state encoding for the instruction fetch unit.
package ifetch_pkg;

  localparam int ADDR_W = 15;
  localparam int WORD_W = 48;
  localparam int INSN_W = 24;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_WAIT  = 3'd1,
    ST_LEFT  = 3'd2,
    ST_RIGHT = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: reads one 48-bit word holding two 24-bit instructions and presents
// them left then right to the decoder, with redirect (jump) and in-flight read draining.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 15'o00001
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] o_iaddr,
  output logic              o_iread,
  input  logic [WORD_W-1:0] i_idata,
  input  logic              i_idone,
  output logic [INSN_W-1:0] o_insn,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_right,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jaddr
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  // Set once the abandoned read has completed while draining.
  logic                drained_q, drained_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    iaddr_d   = iaddr_q;
    word_d    = word_q;
    drained_d = drained_q;
    case (state_q)
      ST_FETCH: begin
        iaddr_d = pc_q;
        if (i_jump) pc_d = i_jaddr;
        // A read is only issued while i_idone is low; a jump in the same cycle orphans it.
        if (!i_idone) begin
          state_d   = i_jump ? ST_DRAIN : ST_WAIT;
          drained_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (i_jump) begin
          pc_d      = i_jaddr;
          state_d   = ST_DRAIN;
          drained_d = i_idone;
        end else if (i_idone) begin
          word_d  = i_idata;
          state_d = ST_LEFT;
        end
      end
      ST_LEFT: begin
        if (i_jump) begin
          pc_d    = i_jaddr;
          state_d = ST_FETCH;
        end else if (i_ready) begin
          state_d = ST_RIGHT;
        end
      end
      ST_RIGHT: begin
        if (i_jump) begin
          pc_d    = i_jaddr;
          state_d = ST_FETCH;
        end else if (i_ready) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (i_jump) pc_d = i_jaddr;
        if (i_idone) begin
          drained_d = 1'b1;
        end else if (drained_q) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      iaddr_q   <= RESET_PC;
      word_q    <= '0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      iaddr_q   <= iaddr_d;
      word_q    <= word_d;
      drained_q <= drained_d;
    end
  end

  // Outputs are gated by reset so the very first reset cycle is already quiet.
  always_comb begin
    o_iread = !reset && !i_idone &&
              ((state_q == ST_FETCH) || (state_q == ST_WAIT) ||
               ((state_q == ST_DRAIN) && !drained_q));
    o_iaddr = (state_q == ST_FETCH) ? pc_q : iaddr_q;
    o_valid = !reset && ((state_q == ST_LEFT) || (state_q == ST_RIGHT));
    o_right = !reset && (state_q == ST_RIGHT);
    if (reset) begin
      o_insn = '0;
    end else if (state_q == ST_RIGHT) begin
      o_insn = word_q[INSN_W-1:0];
    end else begin
      o_insn = word_q[WORD_W-1:INSN_W];
    end
    o_pc = pc_q;
  end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: random-latency memory model, directed redirect/reset
// scenarios, then randomized ready/jump traffic.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] o_iaddr;
  logic        o_iread;
  logic [47:0] i_idata;
  logic        i_idone;
  logic [23:0] o_insn;
  logic        o_valid;
  logic        i_ready;
  logic [14:0] o_pc;
  logic        o_right;
  logic        i_jump;
  logic [14:0] i_jaddr;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(15'o00001)) dut (
    .clk     (clk),
    .reset   (reset),
    .o_iaddr (o_iaddr),
    .o_iread (o_iread),
    .i_idata (i_idata),
    .i_idone (i_idone),
    .o_insn  (o_insn),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_pc    (o_pc),
    .o_right (o_right),
    .i_jump  (i_jump),
    .i_jaddr (i_jaddr)
  );

  typedef struct {
    logic [23:0] insn;
    logic [14:0] pc;
    logic        right;
  } exp_t;

  int          n_chk = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  logic [14:0] rd_log[$];
  logic [14:0] m_pc;
  logic        m_right;

  logic        mon_valid = 1'b0, mon_rd = 1'b0, mon_rst = 1'b1, rst_prev = 1'b0;
  logic [14:0] mon_addr = '0;

  logic        mem_busy = 1'b0;
  logic [14:0] mem_addr = '0;
  int          mem_dly = 0, mem_hold = 0;
  int          mem_dfix = 1, mem_hfix = 1;

  function automatic logic [47:0] word(input logic [14:0] a);
    logic [14:0] b;
    b = a * 15'd3 + 15'd17;
    return {a ^ 15'h2b5d, 9'h1a5, b, 9'h0c3};
  endfunction

  function automatic void chk(input string name, input logic [47:0] got,
                              input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void push_exp();
    exp_t        e;
    logic [47:0] w;
    w       = word(m_pc);
    e.pc    = m_pc;
    e.right = m_right;
    e.insn  = m_right ? w[23:0] : w[47:24];
    exp_q.push_back(e);
  endfunction

  // Monitor: samples on the falling edge and checks presentations against the scoreboard.
  always @(negedge clk) begin
    mon_valid = o_valid;
    mon_rd    = o_iread;
    mon_addr  = o_iaddr;
    mon_rst   = reset;
    if (reset) begin
      chk("rst_iread", 48'(o_iread), 48'(0));
      chk("rst_valid", 48'(o_valid), 48'(0));
      chk("rst_insn", 48'(o_insn), 48'(0));
      chk("rst_right", 48'(o_right), 48'(0));
      if (rst_prev) chk("rst_pc", 48'(o_pc), 48'(1));
    end else begin
      if (i_idone) chk("iread_vs_idone", 48'(o_iread), 48'(0));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL unexpected_valid: got insn %0h pc %0o, required no output",
                   o_insn, o_pc);
        end else begin
          chk("insn", 48'(o_insn), 48'(exp_q[0].insn));
          chk("pc", 48'(o_pc), 48'(exp_q[0].pc));
          chk("right", 48'(o_right), 48'(exp_q[0].right));
          if (i_ready && !i_jump) void'(exp_q.pop_front());
        end
      end
    end
    rst_prev = reset;
  end

  task automatic mem_tick();
    if (mem_dly == 0) begin
      i_idone  = 1'b1;
      i_idata  = word(mem_addr);
      mem_hold = (mem_hfix > 0) ? mem_hfix : int'($urandom_range(1, 2));
    end else begin
      mem_dly--;
    end
  endtask

  // Memory: accepts one read at a time, answers after a delay, holds i_idone 1..n cycles.
  always @(posedge clk) begin
    #1;
    if (mem_busy && i_idone) begin
      if (mem_hold > 1) begin
        mem_hold--;
      end else begin
        i_idone  = 1'b0;
        mem_busy = 1'b0;
      end
    end else if (mem_busy) begin
      if (!mon_rst) begin
        chk("iread_held", 48'(mon_rd), 48'(1));
        chk("iaddr_held", 48'(mon_addr), 48'(mem_addr));
      end
      mem_tick();
    end else if (mon_rd) begin
      mem_busy = 1'b1;
      mem_addr = mon_addr;
      rd_log.push_back(mon_addr);
      mem_dly = (mem_dfix >= 0) ? mem_dfix : int'($urandom_range(0, 3));
      mem_tick();
    end
  end

  task automatic cyc(input logic r, input logic j, input logic [14:0] ja);
    i_ready = r;
    i_jump  = j;
    i_jaddr = ja;
    @(posedge clk);
    #2;
    if (j) begin
      exp_q.delete();
      m_pc    = ja;
      m_right = 1'b0;
      push_exp();
    end else if (mon_valid && r) begin
      if (m_right) begin
        m_pc    = m_pc + 15'd1;
        m_right = 1'b0;
      end else begin
        m_right = 1'b1;
      end
      push_exp();
    end
  endtask

  task automatic rst_cycles(input int n);
    i_ready = 1'b0;
    i_jump  = 1'b0;
    reset   = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
    reset   = 1'b0;
    exp_q.delete();
    m_pc    = 15'd1;
    m_right = 1'b0;
    push_exp();
    rd_log.delete();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    do begin
      cyc(1'b0, 1'b0, 15'd0);
      k++;
    end while (!mon_valid && k < budget);
    if (!mon_valid) chk({name, "_timeout"}, 48'(mon_valid), 48'(1));
  endtask

  task automatic wait_busy(input string name, input int budget);
    int k;
    k = 0;
    while (!(mem_busy && !i_idone) && k < budget) begin
      cyc(1'b0, 1'b0, 15'd0);
      k++;
    end
    if (!(mem_busy && !i_idone)) chk({name, "_timeout"}, 48'(mem_busy), 48'(1));
  endtask

  initial begin
    logic        r, j;
    logic [14:0] ja;
    int          n0, k;
    reset   = 1'b1;
    i_idone = 1'b0;
    i_idata = '0;
    i_ready = 1'b0;
    i_jump  = 1'b0;
    i_jaddr = '0;

    // Reset and the first word pair.
    rst_cycles(3);
    cyc(1'b0, 1'b0, 15'd0);
    chk("iread_after_rst", 48'(mon_rd), 48'(1));
    wait_valid("first_left", 20);
    cyc(1'b1, 1'b0, 15'd0);
    chk("left_accepted", 48'(mon_valid), 48'(1));
    mem_dfix = 3;
    cyc(1'b1, 1'b0, 15'd0);
    chk("right_accepted", 48'(mon_valid), 48'(1));
    wait_busy("fetch2", 10);
    chk("next_iaddr", 48'(mem_addr), 48'(2));
    chk("first_read", 48'(rd_log[0]), 48'(1));

    // Redirect while word 2 is outstanding.
    cyc(1'b0, 1'b1, 15'd7);
    wait_valid("jump7", 40);
    chk("reads_after_jump", 48'(rd_log.size()), 48'(3));
    chk("jump_read_addr", 48'(rd_log[rd_log.size()-1]), 48'(7));

    // Decoder stall in LEFT.
    repeat (5) begin
      cyc(1'b0, 1'b0, 15'd0);
      chk("hold_valid", 48'(mon_valid), 48'(1));
      chk("hold_iread", 48'(mon_rd), 48'(0));
    end

    // Jump and ready together in LEFT.
    n0 = rd_log.size();
    cyc(1'b1, 1'b1, 15'd3);
    cyc(1'b0, 1'b0, 15'd0);
    chk("valid_dropped", 48'(mon_valid), 48'(0));
    wait_valid("jump3", 40);
    chk("reads_after_jump3", 48'(rd_log.size() - n0), 48'(1));
    chk("jump3_addr", 48'(rd_log[n0]), 48'(3));

    // PC wrap from 77777.
    mem_dfix = 1;
    cyc(1'b0, 1'b1, 15'o77777);
    wait_valid("top_word", 40);
    cyc(1'b1, 1'b0, 15'd0);
    mem_dfix = 2;
    mem_hfix = 3;
    cyc(1'b1, 1'b0, 15'd0);
    n0 = rd_log.size();
    k  = 0;
    while (rd_log.size() <= n0 && k < 10) begin
      cyc(1'b0, 1'b0, 15'd0);
      k++;
    end
    chk("wrap_iaddr", 48'(rd_log[n0]), 48'(0));

    // Reset while a read is outstanding.
    wait_busy("wait_before_rst", 10);
    rst_cycles(3);
    wait_valid("post_rst", 40);
    chk("post_rst_reads", 48'(rd_log.size()), 48'(1));
    chk("post_rst_addr", 48'(rd_log[0]), 48'(1));

    // Randomized traffic.
    mem_dfix = -1;
    mem_hfix = 0;
    repeat (800) begin
      r = ($urandom_range(0, 3) != 0);
      j = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0) ja = 15'h7fff - 15'($urandom_range(0, 1));
      else ja = 15'($urandom);
      cyc(r, j, ja);
    end
    wait_valid("final", 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $fatal(1);
  end

endmodule
